// File: rtl/rom_arbiter_pkg.sv
// Shared constants and types for the instruction ROM arbiter.
package rom_arbiter_pkg;

   localparam logic        ChipEnable     = 1'b1;
   localparam logic        ChipDisable    = 1'b0;
   localparam logic [31:0] ZeroInst       = 32'h0000_0000;
   localparam int unsigned InstMemNum     = 4096;
   localparam int unsigned InstMemNumLog2 = 12;

   // Encoding of the most recently granted master.
   typedef enum logic {
      RomArbM0 = 1'b0,
      RomArbM1 = 1'b1
   } rom_arb_master_e;

endpackage

// File: rtl/rom_arb_rr.sv
// Two-way round-robin grant with an m1 burst lock bounded by MAX_LOCK.
module rom_arb_rr
   import rom_arbiter_pkg::*;
#(
   parameter int unsigned MAX_LOCK = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic m0_req_i,
   input  logic m1_req_i,
   input  logic m1_lock_i,
   output logic m0_gnt_o,
   output logic m1_gnt_o
);

   localparam int unsigned LockW = $clog2(MAX_LOCK) + 1;
   localparam logic [LockW-1:0] CapCnt = LockW'(MAX_LOCK - 1);

   rom_arb_master_e  last_gnt_q, last_gnt_d;
   logic [LockW-1:0] lock_cnt_q, lock_cnt_d;
   logic             req0, req1, lock_ovr;

   always_comb begin
      m0_gnt_o   = 1'b0;
      m1_gnt_o   = 1'b0;
      last_gnt_d = last_gnt_q;
      lock_cnt_d = lock_cnt_q;
      // No grants while reset is held, so nothing is accepted that cannot be answered.
      req0       = m0_req_i & ~rst;
      req1       = m1_req_i & ~rst;
      lock_ovr   = m1_lock_i && (last_gnt_q == RomArbM1) && (lock_cnt_q < CapCnt);

      if (req0 && req1) begin
         if (lock_ovr || (last_gnt_q == RomArbM0)) begin
            m1_gnt_o = 1'b1;
         end else begin
            m0_gnt_o = 1'b1;
         end
      end else if (req0) begin
         m0_gnt_o = 1'b1;
      end else if (req1) begin
         m1_gnt_o = 1'b1;
      end

      if (m0_gnt_o) begin
         last_gnt_d = RomArbM0;
      end else if (m1_gnt_o) begin
         last_gnt_d = RomArbM1;
      end

      if (m0_gnt_o || !m1_lock_i) begin
         lock_cnt_d = '0;
      end else if (m1_gnt_o && (lock_cnt_q < CapCnt)) begin
         lock_cnt_d = lock_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt_q <= RomArbM1;
         lock_cnt_q <= '0;
      end else begin
         last_gnt_q <= last_gnt_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

endmodule

// File: rtl/rom_arbiter.sv
// Shares the combinational instruction ROM port between fetch (m0) and load/debug (m1).
module rom_arbiter
   import rom_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned MEM_DEPTH = InstMemNum,
   parameter int unsigned MAX_LOCK  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req_i,
   input  logic [ADDR_W-1:0] m0_addr_i,
   output logic              m0_gnt_o,
   output logic              m0_rvalid_o,
   output logic [DATA_W-1:0] m0_rdata_o,
   input  logic              m1_req_i,
   input  logic              m1_lock_i,
   input  logic [ADDR_W-1:0] m1_addr_i,
   output logic              m1_gnt_o,
   output logic              m1_rvalid_o,
   output logic [DATA_W-1:0] m1_rdata_o,
   output logic              m1_err_o,
   output logic              hold_flag_o,
   output logic              rom_ce_o,
   output logic [ADDR_W-1:0] rom_addr_o,
   input  logic [DATA_W-1:0] rom_inst_i
);

   localparam logic [ADDR_W-3:0] DepthW = (ADDR_W - 2)'(MEM_DEPTH);

   logic              m1_legal;
   logic              m0_rvalid_q, m1_rvalid_q, m1_err_q;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;

   rom_arb_rr #(
      .MAX_LOCK (MAX_LOCK)
   ) u_rr (
      .clk       (clk),
      .rst       (rst),
      .m0_req_i  (m0_req_i),
      .m1_req_i  (m1_req_i),
      .m1_lock_i (m1_lock_i),
      .m0_gnt_o  (m0_gnt_o),
      .m1_gnt_o  (m1_gnt_o)
   );

   assign m1_legal    = (m1_addr_i[1:0] == 2'b00) && (m1_addr_i[ADDR_W-1:2] < DepthW);
   assign hold_flag_o = m0_req_i & ~m0_gnt_o;

   // Fetch is never range-checked; the ROM truncates the index itself.
   always_comb begin
      rom_ce_o   = ChipDisable;
      rom_addr_o = '0;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;
      if (m0_gnt_o) begin
         rom_ce_o   = ChipEnable;
         rom_addr_o = m0_addr_i;
         m0_rdata_d = rom_inst_i;
      end else if (m1_gnt_o) begin
         if (m1_legal) begin
            rom_ce_o   = ChipEnable;
            rom_addr_o = m1_addr_i;
            m1_rdata_d = rom_inst_i;
         end else begin
            m1_rdata_d = DATA_W'(ZeroInst);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m0_rvalid_q <= 1'b0;
         m1_rvalid_q <= 1'b0;
         m1_err_q    <= 1'b0;
         m0_rdata_q  <= '0;
         m1_rdata_q  <= '0;
      end else begin
         m0_rvalid_q <= m0_gnt_o;
         m1_rvalid_q <= m1_gnt_o;
         m1_err_q    <= m1_gnt_o & ~m1_legal;
         m0_rdata_q  <= m0_rdata_d;
         m1_rdata_q  <= m1_rdata_d;
      end
   end

   // Asserting rst drops any pending response immediately.
   assign m0_rvalid_o = m0_rvalid_q & ~rst;
   assign m1_rvalid_o = m1_rvalid_q & ~rst;
   assign m1_err_o    = m1_err_q & ~rst;
   assign m0_rdata_o  = rst ? '0 : m0_rdata_q;
   assign m1_rdata_o  = rst ? '0 : m1_rdata_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed self-checking bench for rom_arbiter with a behavioural ROM.
module tb_rom_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_req, m1_req, m1_lock;
   logic [31:0] m0_addr, m1_addr;
   logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m1_err, hold_flag, rom_ce;
   logic [31:0] m0_rdata, m1_rdata, rom_addr, rom_inst;
   logic [31:0] rom_mem [4096];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   assign rom_inst = rom_mem[rom_addr[13:2]];

   rom_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .m0_req_i    (m0_req),
      .m0_addr_i   (m0_addr),
      .m0_gnt_o    (m0_gnt),
      .m0_rvalid_o (m0_rvalid),
      .m0_rdata_o  (m0_rdata),
      .m1_req_i    (m1_req),
      .m1_lock_i   (m1_lock),
      .m1_addr_i   (m1_addr),
      .m1_gnt_o    (m1_gnt),
      .m1_rvalid_o (m1_rvalid),
      .m1_rdata_o  (m1_rdata),
      .m1_err_o    (m1_err),
      .hold_flag_o (hold_flag),
      .rom_ce_o    (rom_ce),
      .rom_addr_o  (rom_addr),
      .rom_inst_i  (rom_inst)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_req = 0; m1_req = 0; m1_lock = 0; m0_addr = 0; m1_addr = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      step();
      step();
      rst = 0;
   endtask

   task automatic test_reset();
      logic [31:0] outs;
      idle_inputs();
      rst = 1;
      step();
      step();
      outs = {m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m1_err, hold_flag, rom_ce, 25'd0};
      n_checks++;
      if (outs !== 32'd0) begin n_fail++; $display("FAIL reset_ctl got %h want 0", outs); end
      n_checks++;
      if ({m0_rdata, m1_rdata, rom_addr} !== 96'd0) begin
         n_fail++; $display("FAIL reset_data got %h %h %h want 0", m0_rdata, m1_rdata, rom_addr);
      end
      rst = 0;
      step();
      m0_req = 1; m0_addr = 32'h10;
      #1;
      n_checks++;
      if ({m0_gnt, m1_gnt, rom_ce, hold_flag} !== 4'b1010) begin
         n_fail++; $display("FAIL first_fetch_gnt got %b want 1010", {m0_gnt, m1_gnt, rom_ce, hold_flag});
      end
      n_checks++;
      if (rom_addr !== 32'h10) begin n_fail++; $display("FAIL first_fetch_addr got %h want 10", rom_addr); end
      step();
      m0_req = 0;
      n_checks++;
      if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL first_fetch_resp got %b %h want 1 deadbeef", m0_rvalid, m0_rdata);
      end
      step();
      n_checks++;
      if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL fetch_hold got %b %h want 0 deadbeef", m0_rvalid, m0_rdata);
      end
   endtask

   task automatic test_round_robin();
      logic exp0, prev0;
      do_reset();
      m0_req = 1; m0_addr = 32'h0; m1_req = 1; m1_addr = 32'h8;
      prev0 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         exp0 = (i % 2 == 0);
         n_checks++;
         if ({m0_gnt, m1_gnt, hold_flag} !== {exp0, ~exp0, ~exp0}) begin
            n_fail++;
            $display("FAIL rr_gnt[%0d] got %b want %b", i, {m0_gnt, m1_gnt, hold_flag}, {exp0, ~exp0, ~exp0});
         end
         if (i > 0) begin
            n_checks++;
            if ({m0_rvalid, m1_rvalid} !== {prev0, ~prev0}) begin
               n_fail++;
               $display("FAIL rr_rvalid[%0d] got %b want %b", i, {m0_rvalid, m1_rvalid}, {prev0, ~prev0});
            end
         end
         prev0 = exp0;
         step();
      end
      n_checks++;
      if (m0_rdata !== 32'h1000_0000 || m1_rdata !== 32'h1000_0002 || m1_err !== 1'b0) begin
         n_fail++; $display("FAIL rr_rdata got %h %h %b want 10000000 10000002 0", m0_rdata, m1_rdata, m1_err);
      end
      idle_inputs();
   endtask

   task automatic test_lock();
      logic exp0;
      do_reset();
      m0_req = 1; m1_req = 1; m1_lock = 1; m1_addr = 32'h4;
      // Cap reached at i=7; the counter must restart so i=8..14 are m1 again.
      for (int i = 0; i < 16; i++) begin
         #1;
         exp0 = (i == 7) || (i == 15);
         n_checks++;
         if ({m0_gnt, m1_gnt} !== {exp0, ~exp0}) begin
            n_fail++; $display("FAIL lock_gnt[%0d] got %b want %b", i, {m0_gnt, m1_gnt}, {exp0, ~exp0});
         end
         step();
      end
      idle_inputs();
   endtask

   task automatic test_illegal();
      logic [31:0] addrs [4];
      logic [31:0] exp_data [4];
      logic        exp_err [4];
      addrs    = '{32'h6, 32'h4000, 32'h3FFC, 32'hC};
      exp_data = '{32'h0, 32'h0, 32'h1000_0FFF, 32'h1000_0003};
      exp_err  = '{1'b1, 1'b1, 1'b0, 1'b0};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         m1_req = 1; m1_addr = addrs[i];
         #1;
         n_checks++;
         if ({m1_gnt, rom_ce} !== {1'b1, ~exp_err[i]}) begin
            n_fail++; $display("FAIL ill_ce[%0d] got %b want %b", i, {m1_gnt, rom_ce}, {1'b1, ~exp_err[i]});
         end
         n_checks++;
         if (rom_addr !== (exp_err[i] ? 32'h0 : addrs[i])) begin
            n_fail++; $display("FAIL ill_addr[%0d] got %h", i, rom_addr);
         end
         step();
         m1_req = 0;
         n_checks++;
         if ({m1_rvalid, m1_err, m0_rvalid} !== {1'b1, exp_err[i], 1'b0} || m1_rdata !== exp_data[i]) begin
            n_fail++;
            $display("FAIL ill_resp[%0d] got %b %h want %b %h", i, {m1_rvalid, m1_err, m0_rvalid}, m1_rdata,
                     {1'b1, exp_err[i], 1'b0}, exp_data[i]);
         end
      end
      idle_inputs();
      step();
   endtask

   task automatic test_reset_mid_access();
      do_reset();
      m0_req = 1; m0_addr = 32'h0;
      step();
      m0_req = 0; m1_req = 1; m1_addr = 32'h8;
      step();
      m1_req = 0; rst = 1;
      #1;
      n_checks++;
      if ({m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, m1_err, hold_flag, rom_ce} !== 7'd0 ||
          {m0_rdata, m1_rdata, rom_addr} !== 96'd0) begin
         n_fail++; $display("FAIL rst_mid got m1_rvalid=%b m1_rdata=%h m0_rdata=%h", m1_rvalid, m1_rdata, m0_rdata);
      end
      step();
      rst = 0;
      n_checks++;
      if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_drop got %b want 0", m1_rvalid); end
      m0_req = 1; m1_req = 1;
      #1;
      n_checks++;
      if ({m0_gnt, m1_gnt} !== 2'b10) begin
         n_fail++; $display("FAIL rst_conflict got %b want 10", {m0_gnt, m1_gnt});
      end
      step();
      idle_inputs();
      step();
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         m0_req  = (i < 4);
         m0_addr = 32'(4 * i);
         #1;
         if (i < 4) begin
            n_checks++;
            if ({m0_gnt, rom_addr} !== {1'b1, 32'(4 * i)}) begin
               n_fail++; $display("FAIL b2b_gnt[%0d] got %b %h", i, m0_gnt, rom_addr);
            end
         end
         if (i > 0) begin
            n_checks++;
            if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h1000_0000 + 32'(i - 1)) begin
               n_fail++; $display("FAIL b2b_resp[%0d] got %b %h want 1 %h", i, m0_rvalid, m0_rdata,
                                  32'h1000_0000 + 32'(i - 1));
            end
         end
         n_checks++;
         if ({m1_gnt, m1_rvalid, m1_err, m1_rdata} !== 35'd0) begin
            n_fail++; $display("FAIL b2b_m1[%0d] got %b%b%b %h want 0", i, m1_gnt, m1_rvalid, m1_err, m1_rdata);
         end
         step();
      end
      n_checks++;
      if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", m0_rvalid); end
      idle_inputs();
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) rom_mem[i] = 32'h1000_0000 + 32'(i);
      rom_mem[4] = 32'hDEADBEEF;
      idle_inputs();
      rst = 1;
      test_reset();
      test_round_robin();
      test_lock();
      test_illegal();
      test_reset_mid_access();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
